// File: rtl/seq_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_pkg
//   Shared definitions for the bit serializer that feeds the serial sequence
//   detectors.
//   - ser_state_e : 2-bit FSM state encoding. It uses the same numbering as the
//                   state_out port of the detectors, so upper levels can decode
//                   every block's state in the same way.
//   - GAP_CNT_W   : width of the inter-frame gap counter.
//   - eff_len()   : maps a requested frame length to the effective length.
//                   0 and out-of-range requests mean "whole frame".
// -----------------------------------------------------------------------------
package seq_bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_GAP     = 2'd2,
        ST_ILLEGAL = 2'd3
    } ser_state_e;

    // The gap counter covers the full legal GAP_CYCLES range (0..15).
    localparam int GAP_CNT_W = 4;

    // Effective frame length. A length of 0, or one larger than the data
    // width, selects the full data width.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned data_w);
        if ((len == 0) || (len > data_w)) begin
            return data_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Accepts a parallel frame through a valid/ready handshake. It then shifts
//   the frame out one bit per clock on seq_out. After each frame it forces
//   GAP_CYCLES idle cycles, so a downstream detector can settle between test
//   patterns.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   data_in    in   frame bits (sampled only at the accept edge)
//   len_in     in   valid bits in the frame; 0 or >DATA_W selects DATA_W
//   data_valid in   a frame is offered
//   data_ready out  high only in IDLE (combinational)
//   seq_out    out  serial bit stream; IDLE_BIT when no frame bit is shown
//   bit_valid  out  seq_out carries a frame bit this cycle
//   busy       out  FSM is not in IDLE
//   frame_done out  one-cycle pulse in the cycle after the last frame bit
//   state_out  out  current FSM state (IDLE=0, SHIFT=1, GAP=2)
// -----------------------------------------------------------------------------
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_BIT   = 1'b0,
    parameter bit   MSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [$clog2(DATA_W):0] len_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic                    seq_out,
    output logic                    bit_valid,
    output logic                    busy,
    output logic                    frame_done,
    output logic [1:0]              state_out
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    ser_state_e           state_q, state_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 seq_q, seq_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [CNT_W-1:0]     len_eff;
    logic [DATA_W-1:0]    load_aligned;
    logic                 load_first_bit;
    logic [DATA_W-1:0]    load_rest;
    logic                 next_bit;
    logic [DATA_W-1:0]    shreg_shifted;

    assign data_ready = (state_q == ST_IDLE);
    assign accept     = data_valid & data_ready;
    assign len_eff    = CNT_W'(eff_len(32'(len_in), 32'(DATA_W)));

    // The shift register always shifts out from a fixed end. For MSB-first
    // frames shorter than DATA_W, the frame is first moved up so that bit
    // len-1 sits in the MSB. The first bit goes straight into seq_out at the
    // accept edge, so the register is loaded already shifted by one.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign load_aligned   = data_in << (CNT_W'(DATA_W) - len_eff);
            assign load_first_bit = load_aligned[DATA_W-1];
            assign load_rest      = load_aligned << 1;
            assign next_bit       = shreg_q[DATA_W-1];
            assign shreg_shifted  = shreg_q << 1;
        end else begin : g_lsb_first
            assign load_aligned   = data_in;
            assign load_first_bit = load_aligned[0];
            assign load_rest      = load_aligned >> 1;
            assign next_bit       = shreg_q[0];
            assign shreg_shifted  = shreg_q >> 1;
        end
    endgenerate

    // bit_cnt holds the number of frame bits still to present after the one
    // currently on seq_out. When it reaches zero, the next edge ends the frame.
    // gap_cnt holds the number of GAP cycles remaining after the current one.
    // The frame_done cycle is already the first GAP cycle.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        seq_d       = IDLE_BIT;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SHIFT;
                    seq_d       = load_first_bit;
                    bit_valid_d = 1'b1;
                    shreg_d     = load_rest;
                    bit_cnt_d   = len_eff - CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    seq_d       = next_bit;
                    bit_valid_d = 1'b1;
                    shreg_d     = shreg_shifted;
                    bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                end else begin
                    done_d  = 1'b1;
                    shreg_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end
            end

            default: begin
                // Unreachable encoding: go back to IDLE and clear the datapath.
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            seq_q       <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            seq_q       <= seq_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
        end
    end

    assign seq_out    = seq_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_out  = state_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//   dut_m : MSB-first, GAP=2   (table-driven frames plus timing sequences)
//   dut_l : LSB-first, GAP=2   (bit-order sequence)
//   dut_z : MSB-first, GAP=0   (back-to-back without a gap)
//   Bits expected from dut_m are pushed to a scoreboard queue at each accept
//   edge. They are popped and compared whenever dut_m raises bit_valid.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

    localparam int DW = 8;
    localparam int LW = $clog2(DW) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [LW-1:0] len_in = '0;
    logic          valid_m = 1'b0, valid_l = 1'b0, valid_z = 1'b0;

    logic       ready_m, seq_m, bv_m, busy_m, fd_m;
    logic       ready_l, seq_l, bv_l, busy_l, fd_l;
    logic       ready_z, seq_z, bv_z, busy_z, fd_z;
    logic [1:0] st_m, st_l, st_z;

    always #5 clk = ~clk;

    seq_bit_serializer #(.DATA_W(DW), .GAP_CYCLES(2), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .data_in(data_in), .len_in(len_in),
        .data_valid(valid_m), .data_ready(ready_m), .seq_out(seq_m),
        .bit_valid(bv_m), .busy(busy_m), .frame_done(fd_m), .state_out(st_m));

    seq_bit_serializer #(.DATA_W(DW), .GAP_CYCLES(2), .IDLE_BIT(1'b0), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .len_in(len_in),
        .data_valid(valid_l), .data_ready(ready_l), .seq_out(seq_l),
        .bit_valid(bv_l), .busy(busy_l), .frame_done(fd_l), .state_out(st_l));

    seq_bit_serializer #(.DATA_W(DW), .GAP_CYCLES(0), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dut_z (
        .clk(clk), .reset(reset), .data_in(data_in), .len_in(len_in),
        .data_valid(valid_z), .data_ready(ready_z), .seq_out(seq_z),
        .bit_valid(bv_z), .busy(busy_z), .frame_done(fd_z), .state_out(st_z));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    sb_t           sb_q[$];
    logic [31:0]   cur_bits = '0;
    int            cur_len = 0;
    int            cyc = 0;
    int            acc_cyc[$];
    logic          fd_exp = 1'b0;
    int            fd_seen = 0;
    int            frames_exp = 0;

    // Accept detection: sample the handshake at the active edge and push the
    // frame that the driver declared as its expected stream.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset && valid_m && ready_m) begin
            acc_cyc.push_back(cyc);
            for (int k = 0; k < cur_len; k++) begin
                sb_q.push_back('{b: cur_bits[cur_len-1-k], last: (k == cur_len - 1)});
            end
        end
    end

    // Output monitor for dut_m, sampled on the opposite edge.
    initial forever begin
        sb_t e;
        @(negedge clk);
        if (reset) begin
            if (fd_m || fd_exp) begin
                chk("frame_done_timing", 32'(fd_m), 32'(fd_exp));
                if (fd_m) fd_seen++;
            end
            fd_exp = 1'b0;
            if (bv_m) begin
                chk("bv_fd_exclusive", 32'(fd_m), 32'd0);
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_bit");
                end else begin
                    e = sb_q.pop_front();
                    chk("serial_bit", 32'(seq_m), 32'(e.b));
                    if (e.last) fd_exp = 1'b1;
                end
            end else begin
                chk("idle_level", 32'(seq_m), 32'd0);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [LW-1:0] len;
        logic [31:0]   bits;   // expected stream, first bit in bits[n-1]
        int            n;
    } vec_t;

    vec_t vt[8];

    task automatic wait_idle_m(input int budget);
        int n;
        n = 0;
        while (!ready_m && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!ready_m) fail_now("timeout_wait_idle");
    endtask

    // Called at a negedge with dut_m idle; returns in cycle 1 after the accept.
    task automatic send_one_m(input logic [DW-1:0] d, input logic [LW-1:0] l,
                              input logic [31:0] bits, input int n);
        data_in  = d;
        len_in   = l;
        cur_bits = bits;
        cur_len  = n;
        valid_m  = 1'b1;
        @(negedge clk);
        valid_m  = 1'b0;
        frames_exp++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_fd;

        vt[0] = '{8'h05, 4'd3,  32'b101,      3};
        vt[1] = '{8'hA5, 4'd8,  32'b10100101, 8};
        vt[2] = '{8'h3C, 4'd0,  32'b00111100, 8};
        vt[3] = '{8'h81, 4'd9,  32'b10000001, 8};
        vt[4] = '{8'hF0, 4'd1,  32'b0,        1};
        vt[5] = '{8'hFF, 4'd2,  32'b11,       2};
        vt[6] = '{8'h6B, 4'd5,  32'b01011,    5};
        vt[7] = '{8'h80, 4'd15, 32'b10000000, 8};

        // ---- reset ----
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_seq_out",    32'(seq_m),   32'd0);
        chk("rst_bit_valid",  32'(bv_m),    32'd0);
        chk("rst_busy",       32'(busy_m),  32'd0);
        chk("rst_frame_done", 32'(fd_m),    32'd0);
        chk("rst_state",      32'(st_m),    32'd0);
        chk("rst_ready",      32'(ready_m), 32'd1);
        @(negedge clk);

        // ---- table-driven frames ----
        for (int i = 0; i < 8; i++) begin
            send_one_m(vt[i].d, vt[i].len, vt[i].bits, vt[i].n);
            wait_idle_m(40);
            chk("vec_drained", 32'(sb_q.size()), 32'd0);
            chk("vec_idle_state", 32'(st_m), 32'd0);
            $display("frame %0d data=%02h len=%0d bits=%0d", i, vt[i].d, vt[i].len, vt[i].n);
        end

        // ---- basic frame, cycle-exact timing ----
        send_one_m(8'h05, 4'd3, 32'b101, 3);          // now in cycle 1
        chk("basic_c1_state", 32'(st_m), 32'd1);
        chk("basic_c1_bv",    32'(bv_m), 32'd1);
        repeat (3) @(negedge clk);                    // cycle 4
        chk("basic_c4_fd",    32'(fd_m), 32'd1);
        chk("basic_c4_state", 32'(st_m), 32'd2);
        @(negedge clk);                               // cycle 5
        chk("basic_c5_state", 32'(st_m), 32'd2);
        chk("basic_c5_ready", 32'(ready_m), 32'd0);
        @(negedge clk);                               // cycle 6
        chk("basic_c6_ready", 32'(ready_m), 32'd1);
        $display("frame basic data=05 len=3");

        // ---- back-to-back with data_valid held ----
        acc_cyc.delete();
        data_in = 8'hA5; len_in = 4'd8; cur_bits = 32'b10100101; cur_len = 8;
        valid_m = 1'b1;
        @(negedge clk);
        data_in = 8'h3C; len_in = 4'd0; cur_bits = 32'b00111100; cur_len = 8;
        for (int n = 0; n < 30 && acc_cyc.size() < 2; n++) @(negedge clk);
        valid_m = 1'b0;
        frames_exp += 2;
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() == 2) chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
        wait_idle_m(40);
        chk("b2b_drained", 32'(sb_q.size()), 32'd0);
        $display("frame b2b A5/3C");

        // ---- inputs ignored outside the accept edge ----
        acc_cyc.delete();
        data_in = 8'hC3; len_in = 4'd8; cur_bits = 32'b11000011; cur_len = 8;
        valid_m = 1'b1;
        @(negedge clk);                               // cycle 1
        for (int j = 0; j < 9; j++) begin
            data_in = DW'($urandom);
            len_in  = LW'($urandom);
            @(negedge clk);
        end                                           // cycle 10: still GAP
        valid_m = 1'b0;
        frames_exp++;
        wait_idle_m(40);
        chk("ignore_one_accept", 32'(acc_cyc.size()), 32'd1);
        chk("ignore_drained", 32'(sb_q.size()), 32'd0);
        $display("frame ignore-inputs C3");

        // ---- reset mid-frame ----
        send_one_m(8'hB4, 4'd8, 32'b10110100, 8);    // cycle 1
        frames_exp--;                                 // discarded frame
        repeat (4) @(negedge clk);                    // cycle 5: bit 4
        chk("midrst_bv_before", 32'(bv_m), 32'd1);
        saved_fd = fd_seen;
        reset = 1'b0;
        #1;
        chk("midrst_seq",   32'(seq_m),  32'd0);
        chk("midrst_bv",    32'(bv_m),   32'd0);
        chk("midrst_fd",    32'(fd_m),   32'd0);
        chk("midrst_busy",  32'(busy_m), 32'd0);
        chk("midrst_state", 32'(st_m),   32'd0);
        sb_q.delete();
        fd_exp = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready_after", 32'(ready_m), 32'd1);
        chk("midrst_no_done", 32'(fd_seen), 32'(saved_fd));
        @(negedge clk);
        send_one_m(8'hA5, 4'd8, 32'b10100101, 8);
        wait_idle_m(40);
        chk("midrst_new_drained", 32'(sb_q.size()), 32'd0);
        $display("frame after mid-frame reset A5");

        // ---- LSB-first instance ----
        data_in = 8'b0000_0110; len_in = 4'd3; valid_l = 1'b1;
        @(negedge clk);                               // cycle 1
        valid_l = 1'b0;
        chk("lsb_c1_bv",  32'(bv_l),  32'd1);
        chk("lsb_c1_bit", 32'(seq_l), 32'd0);
        @(negedge clk);
        chk("lsb_c2_bit", 32'(seq_l), 32'd1);
        @(negedge clk);
        chk("lsb_c3_bit", 32'(seq_l), 32'd1);
        @(negedge clk);
        chk("lsb_c4_fd",  32'(fd_l),  32'd1);
        chk("lsb_c4_bv",  32'(bv_l),  32'd0);
        $display("frame lsb data=06 len=3");

        // ---- GAP_CYCLES=0 instance, data_valid held ----
        data_in = 8'h05; len_in = 4'd3; valid_z = 1'b1;
        @(negedge clk);                               // cycle 1
        data_in = 8'h03; len_in = 4'd2;
        chk("gap0_c1_bit", 32'(seq_z), 32'd1);
        @(negedge clk);
        chk("gap0_c2_bit", 32'(seq_z), 32'd0);
        @(negedge clk);
        chk("gap0_c3_bit", 32'(seq_z), 32'd1);
        @(negedge clk);                               // cycle 4: frame_done
        chk("gap0_c4_fd",    32'(fd_z),    32'd1);
        chk("gap0_c4_ready", 32'(ready_z), 32'd1);
        chk("gap0_c4_bv",    32'(bv_z),    32'd0);
        @(negedge clk);                               // cycle 5: next first bit
        valid_z = 1'b0;
        chk("gap0_c5_bv",    32'(bv_z),  32'd1);
        chk("gap0_c5_bit",   32'(seq_z), 32'd1);
        chk("gap0_c5_state", 32'(st_z),  32'd1);
        @(negedge clk);
        chk("gap0_c6_bit",   32'(seq_z), 32'd1);
        @(negedge clk);
        chk("gap0_c7_fd",    32'(fd_z),  32'd1);
        @(negedge clk);
        chk("gap0_c8_ready", 32'(ready_z), 32'd1);
        $display("frame gap0 05 then 03");

        // ---- final accounting ----
        repeat (2) @(negedge clk);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_frame_count", 32'(fd_seen), 32'(frames_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
